// File: rtl/game_board_ctrl.sv
`default_nettype none
// ============================================================================
// game_board_ctrl : N x N two-player board with step cursor and win/draw scan
// Revision 1.0
// ============================================================================
module game_board_ctrl #(
    parameter int N      = 3,
    parameter int ORIGIN = 70,
    parameter int PITCH  = 160
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iStep,
    input  logic [3:0]       iDir,
    input  logic             iPlace,
    input  logic             iNew,
    output logic [9:0]       oCursor_X,
    output logic [9:0]       oCursor_Y,
    output logic [2*N*N-1:0] oCells,
    output logic             oPlayer,
    output logic [1:0]       oWinner,
    output logic [1:0]       oState,
    output logic             oBusy,
    output logic             oIllegal
);

    localparam int CW = $clog2(N);
    localparam int IW = $clog2(N*N);
    localparam int MW = $clog2(N*N+1);
    localparam int NL = 2*N + 2;
    localparam int KW = $clog2(NL);

    localparam logic [CW-1:0] C_LAST   = CW'(N-1);
    localparam logic [KW-1:0] C_K_LAST = KW'(NL-1);
    localparam logic [MW-1:0] C_FULL   = MW'(N*N);
    localparam logic [9:0]    C_ORIGIN = 10'(ORIGIN);
    localparam logic [9:0]    C_PITCH  = 10'(PITCH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        OVER  = 2'b10
    } state_t;

    // ---------------- step synchroniser ----------------
    logic s1, s2, s3, warm, armed;
    logic step_pulse;

    // A rise only counts once the button has been seen released after reset,
    // so a button held through reset release is not taken as a step.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            warm  <= 1'b0;
            armed <= 1'b0;
        end else begin
            s1   <= iStep;
            s2   <= s1;
            s3   <= s2;
            warm <= 1'b1;
            if (warm && !s1 && !s2)
                armed <= 1'b1;
        end
    end

    assign step_pulse = s2 & ~s3 & armed;

    // ---------------- game state ----------------
    state_t            state, state_nxt;
    logic [KW-1:0]     k, k_nxt;
    logic [CW-1:0]     col, col_nxt, col_mv;
    logic [CW-1:0]     row, row_nxt, row_mv;
    logic [2*N*N-1:0]  cells, cells_nxt;
    logic              player, player_nxt;
    logic [1:0]        winner, winner_nxt;
    logic [MW-1:0]     moves, moves_nxt;
    logic              illegal, illegal_nxt;
    logic [9:0]        cur_x, cur_y;
    logic [IW-1:0]     tgt;
    logic [1:0]        tgt_code;
    logic [1:0]        cur_code;
    logic [NL-1:0]     line_match;

    assign cur_code = player ? 2'b10 : 2'b01;

    // Cursor after the requested move; opposing directions cancel per axis.
    always_comb begin
        col_mv = col;
        row_mv = row;
        if (iDir[0] && !iDir[1] && col != C_LAST)
            col_mv = col + 1'b1;
        else if (iDir[1] && !iDir[0] && col != '0)
            col_mv = col - 1'b1;
        if (iDir[2] && !iDir[3] && row != C_LAST)
            row_mv = row + 1'b1;
        else if (iDir[3] && !iDir[2] && row != '0)
            row_mv = row - 1'b1;
    end

    assign tgt      = IW'(row_mv) * IW'(N) + IW'(col_mv);
    assign tgt_code = cells[{tgt, 1'b0} +: 2];

    // Line l: rows 0..N-1, then columns, then main and anti diagonal.
    for (genvar gl = 0; gl < NL; gl++) begin : g_line
        logic [N-1:0] hit;
        for (genvar gj = 0; gj < N; gj++) begin : g_cell
            localparam int CI = (gl < N)    ? gl*N + gj :
                                (gl < 2*N)  ? gj*N + (gl - N) :
                                (gl == 2*N) ? gj*N + gj :
                                              gj*N + (N - 1 - gj);
            assign hit[gj] = (cells[2*CI +: 2] == cur_code);
        end
        assign line_match[gl] = &hit;
    end

    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        col_nxt     = col;
        row_nxt     = row;
        cells_nxt   = cells;
        player_nxt  = player;
        winner_nxt  = winner;
        moves_nxt   = moves;
        illegal_nxt = 1'b0;
        if (iNew) begin
            state_nxt  = IDLE;
            k_nxt      = '0;
            col_nxt    = '0;
            row_nxt    = '0;
            cells_nxt  = '0;
            player_nxt = 1'b0;
            winner_nxt = 2'b00;
            moves_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (step_pulse) begin
                        col_nxt = col_mv;
                        row_nxt = row_mv;
                        if (iPlace) begin
                            if (tgt_code == 2'b00) begin
                                cells_nxt[{tgt, 1'b0} +: 2] = cur_code;
                                moves_nxt = moves + 1'b1;
                                k_nxt     = '0;
                                state_nxt = CHECK;
                            end else begin
                                illegal_nxt = 1'b1;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (line_match[k]) begin
                        winner_nxt = cur_code;
                        state_nxt  = OVER;
                    end else if (k == C_K_LAST) begin
                        if (moves == C_FULL) begin
                            winner_nxt = 2'b11;
                            state_nxt  = OVER;
                        end else begin
                            player_nxt = ~player;
                            state_nxt  = IDLE;
                        end
                    end else begin
                        k_nxt = k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= IDLE;
            k       <= '0;
            col     <= '0;
            row     <= '0;
            cells   <= '0;
            player  <= 1'b0;
            winner  <= 2'b00;
            moves   <= '0;
            illegal <= 1'b0;
            cur_x   <= C_ORIGIN;
            cur_y   <= C_ORIGIN;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            col     <= col_nxt;
            row     <= row_nxt;
            cells   <= cells_nxt;
            player  <= player_nxt;
            winner  <= winner_nxt;
            moves   <= moves_nxt;
            illegal <= illegal_nxt;
            cur_x   <= C_ORIGIN + 10'(col_nxt) * C_PITCH;
            cur_y   <= C_ORIGIN + 10'(row_nxt) * C_PITCH;
        end
    end

    assign oCursor_X = cur_x;
    assign oCursor_Y = cur_y;
    assign oCells    = cells;
    assign oPlayer   = player;
    assign oWinner   = winner;
    assign oState    = state;
    assign oBusy     = (state != IDLE);
    assign oIllegal  = illegal;

endmodule
`default_nettype wire
